// File: rtl/rf_access_arbiter_pkg.sv
// Shared definitions for the register-file access arbiter: state encodings,
// requester indices and a small state helper.
package rf_access_arbiter_pkg;

  // Grant states are one-hot on the requester so the state register doubles as gnt_o
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_GRANT0 = 2'b01;
  localparam logic [1:0] ST_GRANT1 = 2'b10;

  localparam int REQ_FX   = 0;
  localparam int REQ_HOST = 1;

  localparam int HOLD_W = 4;

  function automatic logic [1:0] grantState(input logic idx);
    return idx ? ST_GRANT1 : ST_GRANT0;
  endfunction

endpackage

// File: rtl/rf_port_mux.sv
// Selects the granted requester's register-file fields; drives zeros when idle.
module rf_port_mux
  import rf_access_arbiter_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic [1:0]      gnt_i,
  input  logic [1:0]      we_i,
  input  logic [2*AW-1:0] wa_i,
  input  logic [2*DW-1:0] wd_i,
  input  logic [2*AW-1:0] ra1_i,
  input  logic [2*AW-1:0] ra2_i,
  output logic            rf_we_o,
  output logic [AW-1:0]   rf_wa_o,
  output logic [DW-1:0]   rf_wd_o,
  output logic [AW-1:0]   rf_ra1_o,
  output logic [AW-1:0]   rf_ra2_o
);

  always_comb begin
    rf_we_o  = 1'b0;
    rf_wa_o  = '0;
    rf_wd_o  = '0;
    rf_ra1_o = '0;
    rf_ra2_o = '0;
    case (gnt_i)
      ST_GRANT0: begin
        rf_we_o  = we_i[REQ_FX];
        rf_wa_o  = wa_i[REQ_FX*AW +: AW];
        rf_wd_o  = wd_i[REQ_FX*DW +: DW];
        rf_ra1_o = ra1_i[REQ_FX*AW +: AW];
        rf_ra2_o = ra2_i[REQ_FX*AW +: AW];
      end
      ST_GRANT1: begin
        rf_we_o  = we_i[REQ_HOST];
        rf_wa_o  = wa_i[REQ_HOST*AW +: AW];
        rf_wd_o  = wd_i[REQ_HOST*DW +: DW];
        rf_ra1_o = ra1_i[REQ_HOST*AW +: AW];
        rf_ra2_o = ra2_i[REQ_HOST*AW +: AW];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rf_access_arbiter.sv
// Two-requester register-file arbiter: round-robin on contention, lockable
// grants, and a hold timeout that forcibly hands the port to a waiting requester.
module rf_access_arbiter
  import rf_access_arbiter_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 3,
  parameter int TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_i,
  input  logic [1:0]      lock_i,
  input  logic [1:0]      we_i,
  input  logic [2*AW-1:0] wa_i,
  input  logic [2*DW-1:0] wd_i,
  input  logic [2*AW-1:0] ra1_i,
  input  logic [2*AW-1:0] ra2_i,
  input  logic            clear_i,
  output logic [1:0]      gnt_o,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wa,
  output logic [AW-1:0]   rf_ra1,
  output logic [AW-1:0]   rf_ra2,
  output logic [DW-1:0]   rf_wd,
  output logic [1:0]      timeout_o
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              rrPtr_q, rrPtr_d;
  logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
  logic [1:0]        timeout_q, timeout_d;
  logic [1:0]        toSet;
  logic              owner, other;

  assign owner = state_q[1];
  assign other = ~owner;

  // rrPtr_q remembers the last granted requester; the opposite one wins a tie from IDLE
  always_comb begin
    state_d = state_q;
    toSet   = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (req_i[0] && req_i[1]) state_d = grantState(~rrPtr_q);
        else if (req_i[0])        state_d = ST_GRANT0;
        else if (req_i[1])        state_d = ST_GRANT1;
      end
      ST_GRANT0, ST_GRANT1: begin
        if (req_i[other] && (holdCnt_q == HOLD_LIMIT)) begin
          state_d      = grantState(other);
          toSet[owner] = 1'b1;
        end else if (req_i[owner] && (lock_i[owner] || !req_i[other])) begin
          state_d = state_q;
        end else if (req_i[other]) begin
          state_d = grantState(other);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    holdCnt_d = holdCnt_q;
    if (state_d != state_q)
      holdCnt_d = '0;
    else if ((state_q != ST_IDLE) && req_i[other] && (holdCnt_q != '1))
      holdCnt_d = holdCnt_q + 1'b1;
  end

  // A new timeout event outranks a same-cycle clear so it is never lost
  assign rrPtr_d   = ((state_d != state_q) && (state_d != ST_IDLE)) ? state_d[1] : rrPtr_q;
  assign timeout_d = (timeout_q & ~{2{clear_i}}) | toSet;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rrPtr_q   <= 1'b1;
      holdCnt_q <= '0;
      timeout_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      holdCnt_q <= holdCnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_o     = state_q;
  assign timeout_o = timeout_q;

  rf_port_mux #(.DW(DW), .AW(AW)) u_mux (
    .gnt_i    (state_q),
    .we_i     (we_i),
    .wa_i     (wa_i),
    .wd_i     (wd_i),
    .ra1_i    (ra1_i),
    .ra2_i    (ra2_i),
    .rf_we_o  (rf_we),
    .rf_wa_o  (rf_wa),
    .rf_wd_o  (rf_wd),
    .rf_ra1_o (rf_ra1),
    .rf_ra2_o (rf_ra2)
  );

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Scoreboard bench for rf_access_arbiter: a behavioural owner/pointer model
// predicts every cycle's outputs, and a monitor compares them against the DUT.
module tb_rf_access_arbiter;

  localparam int DW      = 32;
  localparam int AW      = 3;
  localparam int TIMEOUT = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_i, lock_i, we_i;
  logic [2*AW-1:0] wa_i, ra1_i, ra2_i;
  logic [2*DW-1:0] wd_i;
  logic            clear_i;
  logic [1:0]      gnt_o, timeout_o;
  logic            rf_we;
  logic [AW-1:0]   rf_wa, rf_ra1, rf_ra2;
  logic [DW-1:0]   rf_wd;

  rf_access_arbiter #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_i),
    .lock_i    (lock_i),
    .we_i      (we_i),
    .wa_i      (wa_i),
    .wd_i      (wd_i),
    .ra1_i     (ra1_i),
    .ra2_i     (ra2_i),
    .clear_i   (clear_i),
    .gnt_o     (gnt_o),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_ra1    (rf_ra1),
    .rf_ra2    (rf_ra2),
    .rf_wd     (rf_wd),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    gnt;
    logic [1:0]    tmo;
    logic          we;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] wd;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   errors = 0;
  int   checks = 0;

  // Reference model: who owns the port, who was granted last, how long the owner has held while the other waits
  int         mOwner = -1;
  int         mLast  = 1;
  int         mHold  = 0;
  logic [1:0] mFlags = 2'b00;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mOwner = -1;
    mLast  = 1;
    mHold  = 0;
    mFlags = 2'b00;
  endtask

  // Drives one cycle of inputs, queues the outputs the model predicts for this cycle, then advances the model
  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] we,
                               input logic [2*AW-1:0] wa, input logic [2*AW-1:0] ra1,
                               input logic [2*AW-1:0] ra2, input logic [2*DW-1:0] wd,
                               input logic clr);
    exp_t       e;
    int         nxt;
    int         oth;
    logic [1:0] setF;
    @(negedge clk);
    req_i   = req;
    lock_i  = lock;
    we_i    = we;
    wa_i    = wa;
    ra1_i   = ra1;
    ra2_i   = ra2;
    wd_i    = wd;
    clear_i = clr;

    e.tmo = mFlags;
    if (mOwner < 0) begin
      e.gnt = 2'b00;
      e.we  = 1'b0;
      e.wa  = '0;
      e.ra1 = '0;
      e.ra2 = '0;
      e.wd  = '0;
    end else begin
      e.gnt = (mOwner == 0) ? 2'b01 : 2'b10;
      e.we  = we[mOwner];
      e.wa  = wa[mOwner*AW +: AW];
      e.ra1 = ra1[mOwner*AW +: AW];
      e.ra2 = ra2[mOwner*AW +: AW];
      e.wd  = wd[mOwner*DW +: DW];
    end
    expQ.push_back(e);

    setF = 2'b00;
    nxt  = mOwner;
    if (mOwner < 0) begin
      if (req == 2'b11)  nxt = 1 - mLast;
      else if (req[0])   nxt = 0;
      else if (req[1])   nxt = 1;
    end else begin
      oth = 1 - mOwner;
      if (req[oth] && (mHold == TIMEOUT - 1)) begin
        nxt          = oth;
        setF[mOwner] = 1'b1;
      end else if (req[mOwner] && (lock[mOwner] || !req[oth])) nxt = mOwner;
      else if (req[oth]) nxt = oth;
      else               nxt = -1;
    end
    if (nxt != mOwner)                                       mHold = 0;
    else if (mOwner >= 0 && req[1 - mOwner] && mHold < 15)   mHold++;
    if (nxt >= 0 && nxt != mOwner) mLast = nxt;
    mFlags = (clr ? 2'b00 : mFlags) | setF;
    mOwner = nxt;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    req_i   = 2'b00;
    lock_i  = 2'b00;
    we_i    = 2'b00;
    clear_i = 1'b0;
    reset   = 1'b1;
    #2;
    reset   = 1'b0;
    modelReset();
  endtask

  // Monitor: the DUT presents a result every cycle; compare it against the oldest prediction
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (expQ.size() > 0) begin
        monE = expQ.pop_front();
        checkOutput("gnt_o",     64'(gnt_o),     64'(monE.gnt));
        checkOutput("timeout_o", 64'(timeout_o), 64'(monE.tmo));
        checkOutput("rf_we",     64'(rf_we),     64'(monE.we));
        checkOutput("rf_wa",     64'(rf_wa),     64'(monE.wa));
        checkOutput("rf_ra1",    64'(rf_ra1),    64'(monE.ra1));
        checkOutput("rf_ra2",    64'(rf_ra2),    64'(monE.ra2));
        checkOutput("rf_wd",     64'(rf_wd),     64'(monE.wd));
      end
    end
  end

  initial begin
    reset   = 1'b1;
    req_i   = 2'b00;
    lock_i  = 2'b00;
    we_i    = 2'b00;
    wa_i    = '0;
    ra1_i   = '0;
    ra2_i   = '0;
    wd_i    = '0;
    clear_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_gnt",     64'(gnt_o),     64'd0);
    checkOutput("reset_timeout", 64'(timeout_o), 64'd0);
    checkOutput("reset_rf_we",   64'(rf_we),     64'd0);
    reset = 1'b0;
    modelReset();

    // Single request with a write from requester 0
    applyStimulus(2'b01, 2'b00, 2'b01, {3'd5, 3'd3}, {3'd1, 3'd2}, {3'd6, 3'd4}, {32'hdead, 32'h80}, 1'b0);
    applyStimulus(2'b01, 2'b00, 2'b01, {3'd5, 3'd3}, {3'd1, 3'd2}, {3'd6, 3'd4}, {32'hdead, 32'h80}, 1'b0);
    idleCycles(2);

    // Contention with no locks alternates every cycle, requester 0 first
    pulseReset();
    for (int i = 0; i < 6; i++)
      applyStimulus(2'b11, 2'b00, 2'b11, {3'd7, 3'd1}, {3'd2, 3'd3}, {3'd4, 3'd5}, {32'h1111, 32'h2222}, 1'b0);
    idleCycles(2);

    // Locked solo requester keeps the grant without building hold time
    for (int i = 0; i < 5; i++)
      applyStimulus(2'b01, 2'b01, 2'b01, {3'd0, 3'd6}, '0, '0, {32'h0, 32'h55}, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(2'b01, 2'b00, 2'b00, {3'd0, 3'd6}, '0, '0, {32'h0, 32'h55}, 1'b0);
    idleCycles(2);

    // Locked requester 0 versus waiting requester 1: forced handover and sticky flag
    pulseReset();
    for (int i = 0; i < 12; i++)
      applyStimulus(2'b11, 2'b01, 2'b11, {3'd2, 3'd1}, '0, '0, {32'hbb, 32'haa}, 1'b0);
    idleCycles(3);
    applyStimulus(2'b00, 2'b00, 2'b00, '0, '0, '0, '0, 1'b1);
    idleCycles(2);

    // Asynchronous reset in the middle of a requester-1 write
    pulseReset();
    applyStimulus(2'b10, 2'b00, 2'b10, {3'd4, 3'd0}, '0, '0, {32'hcafe, 32'h0}, 1'b0);
    applyStimulus(2'b10, 2'b00, 2'b10, {3'd4, 3'd0}, '0, '0, {32'hcafe, 32'h0}, 1'b0);
    #7;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_gnt",   64'(gnt_o), 64'd0);
    checkOutput("async_reset_rf_we", 64'(rf_we), 64'd0);
    @(negedge clk);
    req_i  = 2'b00;
    we_i   = 2'b00;
    reset  = 1'b0;
    modelReset();
    applyStimulus(2'b11, 2'b00, 2'b11, {3'd4, 3'd1}, '0, '0, {32'h2, 32'h1}, 1'b0);
    applyStimulus(2'b11, 2'b00, 2'b11, {3'd4, 3'd1}, '0, '0, {32'h2, 32'h1}, 1'b0);
    idleCycles(2);

    // Random traffic, locks biased high so timeouts occur
    for (int i = 0; i < 400; i++) begin
      logic [1:0] rq, lk;
      rq[0] = ($urandom_range(0, 3) != 0);
      rq[1] = ($urandom_range(0, 3) != 0);
      lk[0] = ($urandom_range(0, 7) != 0);
      lk[1] = ($urandom_range(0, 7) != 0);
      applyStimulus(rq, lk, 2'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
                    {$urandom, $urandom}, ($urandom_range(0, 15) == 0));
    end
    idleCycles(2);

    @(negedge clk);
    #5;
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
